// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Brief    : Shared AES constants, FSM state encoding and GF(2^8) helpers
//            used by the inverse-cipher sequencer and its round datapath.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int NB        = 4;
  localparam int NR_128    = 10;
  localparam int NR_192    = 12;
  localparam int NR_256    = 14;
  localparam int RK_ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } aesState_t;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 = a^-1 for nonzero a; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gfMul(sq, sq);
      r  = gfMul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse.
  function automatic logic [7:0] invSbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gfInv(t);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: aes_inv_cipher_ctrl_if
// Brief    : Block-in / block-out handshakes, key-memory port and status of
//            the AES inverse-cipher sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_ctrl_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [0:AES_BLK_W-1] in_data;
  logic [RK_ADDR_W-1:0] rk_addr;
  logic [0:AES_BLK_W-1] rk_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:AES_BLK_W-1] out_data;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, rk_data, out_ready,
    output in_ready, rk_addr, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rk_data, out_ready,
    input  in_ready, rk_addr, out_valid, out_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_round
// Brief    : Combinational AES inverse round:
//            InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
//            with InvMixColumns bypassed when last is high.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:AES_BLK_W-1] stateIn,
  input  logic [0:AES_BLK_W-1] roundKey,
  input  logic                 last,
  output logic [0:AES_BLK_W-1] stateOut
);

  logic [0:AES_BLK_W-1] w_shifted;
  logic [0:AES_BLK_W-1] w_subbed;
  logic [0:AES_BLK_W-1] w_keyed;
  logic [0:AES_BLK_W-1] w_mixed;

  // State byte (row r, column c) sits at index r + 4c.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r rotates right by r positions.
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign w_shifted[8*(r+4*c) +: 8] = stateIn[8*SRC +: 8];
      assign w_subbed[8*(r+4*c) +: 8]  = invSbox(w_shifted[8*(r+4*c) +: 8]);
    end

    logic [7:0] w_b0, w_b1, w_b2, w_b3;
    assign w_b0 = w_keyed[32*c      +: 8];
    assign w_b1 = w_keyed[32*c + 8  +: 8];
    assign w_b2 = w_keyed[32*c + 16 +: 8];
    assign w_b3 = w_keyed[32*c + 24 +: 8];

    assign w_mixed[32*c      +: 8] = gfMul(8'h0e, w_b0) ^ gfMul(8'h0b, w_b1) ^ gfMul(8'h0d, w_b2) ^ gfMul(8'h09, w_b3);
    assign w_mixed[32*c + 8  +: 8] = gfMul(8'h09, w_b0) ^ gfMul(8'h0e, w_b1) ^ gfMul(8'h0b, w_b2) ^ gfMul(8'h0d, w_b3);
    assign w_mixed[32*c + 16 +: 8] = gfMul(8'h0d, w_b0) ^ gfMul(8'h09, w_b1) ^ gfMul(8'h0e, w_b2) ^ gfMul(8'h0b, w_b3);
    assign w_mixed[32*c + 24 +: 8] = gfMul(8'h0b, w_b0) ^ gfMul(8'h0d, w_b1) ^ gfMul(8'h09, w_b2) ^ gfMul(8'h0e, w_b3);
  end

  assign w_keyed  = w_subbed ^ roundKey;
  assign stateOut = last ? w_keyed : w_mixed;

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_ctrl
// Brief    : Iterative AES inverse-cipher sequencer. Takes one ciphertext
//            block, walks round keys NR..0 from an external key memory
//            through one shared inverse-round datapath, returns plaintext.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_ctrl_if.slave bus
);

  localparam logic [RK_ADDR_W-1:0] c_nrAddr = RK_ADDR_W'(NR);
  localparam logic [RK_ADDR_W-1:0] c_nrLast = RK_ADDR_W'(NR - 1);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_nrCheck
    $error("aes_inv_cipher_ctrl: NR=%0d is not a legal AES round count (10, 12 or 14)", NR);
  end

  aesState_t            r_fsm;
  logic [0:AES_BLK_W-1] r_state;
  logic [3:0]           r_rnd;
  logic [RK_ADDR_W-1:0] r_rkAddr;
  logic                 r_inReady;
  logic                 r_outValid;
  logic                 r_busy;
  logic                 w_last;
  logic [0:AES_BLK_W-1] w_roundOut;

  assign w_last = (r_fsm == FINAL);

  aes_inv_round u_round (
    .stateIn  (r_state),
    .roundKey (bus.rk_data),
    .last     (w_last),
    .stateOut (w_roundOut)
  );

  // Sequencer: accept, whiten with key NR, NR-1 full rounds, final round, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_state    <= '0;
      r_rnd      <= '0;
      r_rkAddr   <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_state   <= bus.in_data;
            r_rkAddr  <= c_nrAddr;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_fsm     <= INIT;
          end
        end
        INIT: begin
          r_state  <= r_state ^ bus.rk_data;
          r_rnd    <= c_nrLast;
          r_rkAddr <= c_nrLast;
          r_fsm    <= ROUND;
        end
        ROUND: begin
          r_state <= w_roundOut;
          if (r_rnd == 4'd1) begin
            r_rkAddr <= '0;
            r_fsm    <= FINAL;
          end else begin
            r_rnd    <= r_rnd - 4'd1;
            r_rkAddr <= r_rnd - 4'd1;
          end
        end
        FINAL: begin
          r_state    <= w_roundOut;
          r_outValid <= 1'b1;
          r_fsm      <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_inReady  <= 1'b1;
            r_fsm      <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.rk_addr   = r_rkAddr;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_state;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_cipher_ctrl
// Brief    : Scoreboard bench for the AES inverse-cipher sequencer with
//            NR=10 and NR=12 instances and FIPS-197 / SP800-38A vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_ctrl;

  localparam int NR_A = 10;
  localparam int NR_B = 12;

  localparam logic [0:255] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] KEY_C2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] KEY_STD = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_E1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [0:127] PT_E1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [0:127] CT_E2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [0:127] PT_E2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [0:127] JUNK  = 128'hdeadbeefcafef00d0123456789abcdef;

  typedef struct {
    logic [0:127] exp;
    int           acc;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_ctrl_if bA ();
  aes_inv_cipher_ctrl_if bB ();

  aes_inv_cipher_ctrl #(.NR(NR_A)) dutA (.clk(clk), .rst_n(rst_n), .bus(bA.slave));
  aes_inv_cipher_ctrl #(.NR(NR_B)) dutB (.clk(clk), .rst_n(rst_n), .bus(bB.slave));

  logic [0:127] memA  [0:15];
  logic [0:127] memB  [0:15];
  logic [0:127] rkTmp [0:15];
  assign bA.rk_data = memA[bA.rk_addr];
  assign bB.rk_data = memB[bB.rk_addr];

  item_t qA[$];
  item_t qB[$];
  int    nChecks = 0;
  int    nErr    = 0;
  int    lastAcc = 0;

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Key-schedule model (forward S-box by brute-force field inverse).
  function automatic logic [7:0] tbMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tbSbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 1; k < 256; k++) if (tbMul(a, 8'(k)) == 8'h01) v = 8'(k);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [0:255] key, input int nk);
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = {t[23:0], t[31:24]};
          t  = {tbSbox(t[31:24]), tbSbox(t[23:16]), tbSbox(t[15:8]), tbSbox(t[7:0])} ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rkTmp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic send(input bit useB, input logic [0:127] ct, input logic [0:127] pt);
    item_t it;
    int    n;
    logic  rdy;
    n = 0;
    if (useB) begin bB.in_data = ct; bB.in_valid = 1'b1; end
    else      begin bA.in_data = ct; bA.in_valid = 1'b1; end
    do begin
      @(negedge clk);
      n++;
      rdy = useB ? bB.in_ready : bA.in_ready;
    end while (!rdy && n < 100);
    if (!rdy) begin
      nChecks++;
      nErr++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      it.exp  = pt;
      it.acc  = cyc;
      lastAcc = cyc;
      if (useB) qB.push_back(it); else qA.push_back(it);
    end
    @(posedge clk); #1;
    if (useB) bB.in_valid = 1'b0; else bA.in_valid = 1'b0;
  endtask

  task automatic drain(input bit useB);
    int n;
    n = 0;
    while ((useB ? qB.size() : qA.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(useB ? "B_drain_outstanding" : "A_drain_outstanding", useB ? qB.size() : qA.size(), 0);
  endtask

  // Output monitor, NR=10 instance: data and latency on first valid, stability while held.
  bit seenA = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst_n && bA.out_valid) begin
      if (qA.size() == 0) begin
        if (!seenA) begin
          nChecks++;
          nErr++;
          $display("FAIL A_unexpected_output: got out_valid=1 data %h, expected no output", bA.out_data);
        end
        seenA = 1'b1;
      end else if (!seenA) begin
        chk("A_plaintext", bA.out_data, qA[0].exp);
        chk("A_latency", cyc - qA[0].acc, NR_A + 2);
        seenA = 1'b1;
      end else begin
        chk("A_hold_out_data", bA.out_data, qA[0].exp);
        chk("A_hold_in_ready", bA.in_ready, 1'b0);
      end
      if (bA.out_ready) begin
        if (qA.size() != 0) void'(qA.pop_front());
        seenA = 1'b0;
      end
    end
  end

  // Output monitor, NR=12 instance.
  bit seenB = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst_n && bB.out_valid) begin
      if (qB.size() == 0) begin
        if (!seenB) begin
          nChecks++;
          nErr++;
          $display("FAIL B_unexpected_output: got out_valid=1 data %h, expected no output", bB.out_data);
        end
        seenB = 1'b1;
      end else if (!seenB) begin
        chk("B_plaintext", bB.out_data, qB[0].exp);
        chk("B_latency", cyc - qB[0].acc, NR_B + 2);
        seenB = 1'b1;
      end
      if (bB.out_ready) begin
        if (qB.size() != 0) void'(qB.pop_front());
        seenB = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int acc1;
    rst_n        = 1'b0;
    bA.in_valid  = 1'b0;
    bA.in_data   = '0;
    bA.out_ready = 1'b1;
    bB.in_valid  = 1'b0;
    bB.in_data   = '0;
    bB.out_ready = 1'b1;
    expand(KEY_C1, 4);
    memA = rkTmp;
    expand(KEY_C2, 6);
    memB = rkTmp;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready",  bA.in_ready,  1'b1);
    chk("reset_out_valid", bA.out_valid, 1'b0);
    chk("reset_busy",      bA.busy,      1'b0);
    chk("reset_rk_addr",   bA.rk_addr,   4'd0);
    chk("reset_out_data",  bA.out_data,  128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.2, NR=12
    send(1'b1, CT_C2, PT_C);
    drain(1'b1);

    // FIPS-197 C.1, NR=10, with round-key address walk
    @(posedge clk); #1;
    send(1'b0, CT_C1, PT_C);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("A_rk_addr_seq", bA.rk_addr, (k <= 11) ? 4'(11 - k) : 4'd0);
      if (k == 1) chk("A_busy_in_init", bA.busy, 1'b1);
    end
    drain(1'b0);

    // Backpressure with ignored input pulses
    @(posedge clk); #1;
    bA.out_ready = 1'b0;
    send(1'b0, CT_C1, PT_C);
    repeat (2) @(posedge clk);
    #1;
    bA.in_data  = JUNK;
    bA.in_valid = 1'b1;
    @(posedge clk); #1;
    bA.in_valid = 1'b0;
    n = 0;
    while (!bA.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("A_bp_out_valid_seen", bA.out_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bA.in_valid = (i == 4 || i == 11);
    end
    bA.in_valid  = 1'b0;
    bA.out_ready = 1'b1;
    drain(1'b0);
    @(negedge clk);
    chk("A_in_ready_after_handshake",  bA.in_ready,  1'b1);
    chk("A_out_valid_after_handshake", bA.out_valid, 1'b0);

    // Back-to-back blocks under the FIPS-197 Appendix B key
    expand(KEY_STD, 4);
    memA = rkTmp;
    @(posedge clk); #1;
    send(1'b0, CT_B, PT_B);
    acc1 = lastAcc;
    send(1'b0, CT_E1, PT_E1);
    chk("A_b2b_accept_period", lastAcc - acc1, NR_A + 3);
    drain(1'b0);

    // Reset in the middle of ROUND, then recovery
    @(posedge clk); #1;
    send(1'b0, CT_E2, PT_E2);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  bA.in_ready,  1'b1);
    chk("midrst_out_valid", bA.out_valid, 1'b0);
    chk("midrst_busy",      bA.busy,      1'b0);
    chk("midrst_rk_addr",   bA.rk_addr,   4'd0);
    qA.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, CT_E2, PT_E2);
    drain(1'b0);

    repeat (5) @(negedge clk);
    chk("A_idle_at_end", bA.busy, 1'b0);
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES inverse-cipher sequencer. Accepts one 128-bit ciphertext block over a valid/ready handshake and drives one shared inverse-round datapath once per clock for NR rounds. Round keys come from an external synchronous-read key memory. The block returns the plaintext over a second valid/ready handshake. It sits between the block-input interface and the existing combinational InvShiftRows / InvSubBytes / AddRoundKey / InvMixColumns stages.

## Interface
- NR, default 10: number of rounds; only 10, 12 or 14 are legal, any other value is an elaboration error.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- in_valid  in  1: ciphertext block offered.
- in_ready  out  1: block can be accepted; high only in IDLE.
- in_data  in  [0:127]: ciphertext; byte 0 is bits [0:7], column-major state.
- rk_addr  out  4: registered round-key index into the key memory.
- rk_data  in  [0:127]: round key; valid the cycle after rk_addr is registered.
- out_valid  out  1: plaintext available.
- out_ready  in  1: consumer accepts the plaintext.
- out_data  out  [0:127]: plaintext; same byte order as in_data.
- busy  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, load the state register with in_data, set rk_addr<=NR, go to INIT.
- INIT:
  - state <= state ^ rk_data (round key NR).
  - rnd <= NR-1, rk_addr <= NR-1, go to ROUND.
- ROUND:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data).
  - If rnd==1: rk_addr <= 0, go to FINAL.
  - Else: rnd <= rnd-1, rk_addr <= rnd-1.
- FINAL:
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk_data (round key 0).
  - Go to DONE.
- DONE:
  - out_valid=1, out_data=state.
  - On out_ready, go to IDLE.
- in_valid outside IDLE is ignored; no input data is sampled.
- out_data is driven from the state register at all times. It is meaningful only while out_valid=1 and must stay stable until the handshake completes.
- rnd is 4 bits, counts down and never wraps. INIT always loads it with NR-1 (≥9).
- Reset values (asynchronous on rst_n low), in all states including mid-operation:
  - FSM=IDLE, state=0, rnd=0, rk_addr=0.
  - in_ready=1 after reset, out_valid=0, busy=0.
  - Any block in flight is discarded and no out_valid is produced for it.

## Timing
- Accept handshake in cycle 0.
- INIT in cycle 1, ROUND in cycles 2..NR, FINAL in cycle NR+1.
- out_valid first high in cycle NR+2, so latency is NR+2 cycles: 12 for NR=10, 14 for NR=12, 16 for NR=14.
- rk_addr sequence for NR=10:
  - cycle 0→1: 10
  - cycles 1..10: 9 down to 0, one step per cycle
  - held at 0 through FINAL/DONE
- rk_addr reaches 0 on entering FINAL; the key memory is read-only during operation.
- If out_ready is already high when DONE is entered, the output handshake completes in the first DONE cycle.
- in_ready rises in the cycle after the output handshake. Minimum per-block period is NR+3 cycles.
- There is no overlap of input accept and output completion.
- out_ready low holds DONE indefinitely; out_data and out_valid must not change.

## Structure
- Shared package aes_pkg holds:
  - AES_BLK_W=128, NB=4, the legal NR values
  - the FSM state enum {IDLE, INIT, ROUND, FINAL, DONE}
  - an RK_ADDR_W=4 constant
- One sub-module, aes_inv_round: purely combinational.
  - Instantiates InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns.
  - Has a `last` input that bypasses InvMixColumns.
  - The controller drives `last` = (FSM==FINAL).
- The INIT XOR is done in the controller. The FSM, counter and registers live in aes_inv_cipher_ctrl only.

## Test plan
- FIPS-197 C.1 (NR=10), key memory preloaded with the expanded key of 000102030405060708090a0b0c0d0e0f:
  - in_data 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff.
  - out_valid first in cycle 12.
  - rk_addr sequence 10,9,…,0.
- FIPS-197 C.2 (NR=12), key 000102…1617:
  - in_data dda97ca4864cdfe06eaf70a0ec0d7191 → out_data 00112233445566778899aabbccddeeff.
  - Latency 14.
- Backpressure: out_ready held low for 20 cycles after out_valid.
  - out_data stable throughout, in_ready=0.
  - in_valid pulses during busy are not accepted.
- Back-to-back: in_valid and out_ready held high with two blocks.
  - Second accept occurs exactly NR+3 cycles after the first.
  - Both plaintexts are correct.
- Reset mid-operation: assert rst_n=0 in cycle 5 (ROUND).
  - Immediately FSM=IDLE, out_valid=0, busy=0, rk_addr=0.
  - A subsequent block decrypts correctly.
- Illegal NR=11: elaboration fails.
